// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI4-Lite response codes, command-master FSM states and PROT default
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4
  } state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding command-port to AXI4-Lite initiator
// Optional watchdog flag TIMEOUT_O compiled in with AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 16,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WR,
  input  logic [C_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                      RSP_VALID,
  output logic                      RSP_WR,
  output logic [1:0]                RSP_RESP,
  output logic [C_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [2:0]                M_AXI_AWPROT,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  output logic [2:0]                M_AXI_ARPROT,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  ,
  output logic                      TIMEOUT_O
`endif
);

  if (C_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi_lite_cmd_master supports only C_DATA_WIDTH = 32");
  end
  if (C_TIMEOUT_CYCLES < 2 || C_TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("axi_lite_cmd_master C_TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  state_e                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_wr_q, rsp_wr_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic [C_DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [C_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [C_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        accept;
  logic                        aw_fin, w_fin;

  assign accept = (state_q == ST_IDLE) && cmd_ready_q && CMD_VALID;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_fin      = aw_done_q || (awvalid_q && M_AXI_AWREADY);
    w_fin       = w_done_q || (wvalid_q && M_AXI_WREADY);

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = CMD_ADDR;
          wdata_d     = CMD_WDATA;
          wstrb_d     = CMD_WSTRB;
          if (CMD_WR) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_AW_W: begin
        // AW and W retire independently; the finished one stays low meanwhile
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end
      ST_WR_B: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b1;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b0;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;

  // Flag only; the transaction keeps waiting so the responder never sees a broken handshake
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (state_q != ST_IDLE && to_cnt_q != 16'hFFFF) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    if (state_q != ST_IDLE && state_d == state_q && to_cnt_d == 16'(C_TIMEOUT_CYCLES - 1)) begin
      timeout_d = 1'b1;
    end
    if (accept) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT_O = timeout_q;
`endif

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_WR        = rsp_wr_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - randomized self-checking bench with byte-level memory reference model
module tb_axi_lite_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CMD_VALID = 1'b0, CMD_WR = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic [3:0]  CMD_WSTRB = '0;
  logic        RSP_VALID, RSP_WR;
  logic [1:0]  RSP_RESP;
  logic [31:0] RSP_RDATA;
  logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
  logic [31:0] M_AXI_RDATA = '0;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  logic        TIMEOUT_O;
`endif

  axi_lite_cmd_master #(.C_ADDR_WIDTH(16), .C_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(TO)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_WR(RSP_WR), .RSP_RESP(RSP_RESP), .RSP_RDATA(RSP_RDATA),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    , .TIMEOUT_O(TIMEOUT_O)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // Responder configuration, set by the tests before each command
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Responder memory and monitor state
  logic [31:0] rmem [16] = '{default: 32'h0};
  int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
  int cyc = 0, acc_cyc = -1, aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1, rsp_cyc = -1;
  int br_rise_cyc = -1, to_rise_cyc = -1;
  int rsp_cnt = 0, rsp_double = 0, viol = 0, awv_cnt = 0, wv_cnt = 0;
  logic        rsp_wr_s = 1'b0;
  logic [1:0]  rsp_resp_s = '0;
  logic [31:0] rsp_rdata_s = '0;
  logic [15:0] lat_awaddr = '0, lat_araddr = '0;
  logic [31:0] lat_wdata = '0;
  logic [3:0]  lat_wstrb = '0;
  logic        rsp_prev = 1'b0, br_prev = 1'b0, to_prev = 1'b0, rst_prev = 1'b0;
  logic        awv_prev = 1'b0, awr_prev = 1'b0, wv_prev = 1'b0, wr_prev = 1'b0;
  logic        arv_prev = 1'b0, arr_prev = 1'b0;
  logic [15:0] awaddr_prev = '0, araddr_prev = '0;
  logic [35:0] w_prev = '0;

  // Reference model: byte-addressed memory
  byte unsigned mdl [64];

  always @(negedge clk) begin
    if (!rst_n) begin
      M_AXI_AWREADY <= 1'b0; M_AXI_WREADY <= 1'b0; M_AXI_BVALID <= 1'b0;
      M_AXI_ARREADY <= 1'b0; M_AXI_RVALID <= 1'b0;
      aw_w <= 0; w_w <= 0; b_w <= 0; ar_w <= 0; r_w <= 0;
    end else begin
      M_AXI_AWREADY <= M_AXI_AWVALID && (aw_w >= aw_dly);
      aw_w          <= M_AXI_AWVALID ? aw_w + 1 : 0;
      M_AXI_WREADY  <= M_AXI_WVALID && (w_w >= w_dly);
      w_w           <= M_AXI_WVALID ? w_w + 1 : 0;
      M_AXI_BVALID  <= M_AXI_BREADY && (b_w >= b_dly);
      b_w           <= M_AXI_BREADY ? b_w + 1 : 0;
      M_AXI_BRESP   <= bresp_cfg;
      M_AXI_ARREADY <= M_AXI_ARVALID && (ar_w >= ar_dly);
      ar_w          <= M_AXI_ARVALID ? ar_w + 1 : 0;
      M_AXI_RVALID  <= M_AXI_RREADY && (r_w >= r_dly);
      r_w           <= M_AXI_RREADY ? r_w + 1 : 0;
      M_AXI_RRESP   <= rresp_cfg;
      M_AXI_RDATA   <= (M_AXI_RREADY && (r_w >= r_dly)) ? rmem[lat_araddr[5:2]] : 32'h0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (CMD_VALID && CMD_READY) acc_cyc <= cyc;
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_hs_cyc <= cyc; lat_awaddr <= M_AXI_AWADDR; end
    if (M_AXI_WVALID && M_AXI_WREADY) begin w_hs_cyc <= cyc; lat_wdata <= M_AXI_WDATA; lat_wstrb <= M_AXI_WSTRB; end
    if (M_AXI_BVALID && M_AXI_BREADY)
      rmem[lat_awaddr[5:2]] <= (lat_wdata & {{8{lat_wstrb[3]}}, {8{lat_wstrb[2]}}, {8{lat_wstrb[1]}}, {8{lat_wstrb[0]}}})
                             | (rmem[lat_awaddr[5:2]] & ~{{8{lat_wstrb[3]}}, {8{lat_wstrb[2]}}, {8{lat_wstrb[1]}}, {8{lat_wstrb[0]}}});
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs_cyc <= cyc; lat_araddr <= M_AXI_ARADDR; end
    if (RSP_VALID) begin
      rsp_cyc <= cyc; rsp_cnt <= rsp_cnt + 1;
      rsp_wr_s <= RSP_WR; rsp_resp_s <= RSP_RESP; rsp_rdata_s <= RSP_RDATA;
      if (rsp_prev) rsp_double <= rsp_double + 1;
    end
    if (M_AXI_BREADY && !br_prev) br_rise_cyc <= cyc;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    if (TIMEOUT_O && !to_prev) to_rise_cyc <= cyc;
    to_prev <= TIMEOUT_O;
`endif
    awv_cnt <= awv_cnt + int'(M_AXI_AWVALID);
    wv_cnt  <= wv_cnt + int'(M_AXI_WVALID);
    // VALID must not drop or change payload before its handshake (reset excepted)
    if (rst_n && rst_prev) begin
      if (awv_prev && !awr_prev && (!M_AXI_AWVALID || M_AXI_AWADDR != awaddr_prev)) viol <= viol + 1;
      if (wv_prev && !wr_prev && (!M_AXI_WVALID || {M_AXI_WSTRB, M_AXI_WDATA} != w_prev)) viol <= viol + 1;
      if (arv_prev && !arr_prev && (!M_AXI_ARVALID || M_AXI_ARADDR != araddr_prev)) viol <= viol + 1;
    end
    rst_prev <= rst_n; rsp_prev <= RSP_VALID; br_prev <= M_AXI_BREADY;
    awv_prev <= M_AXI_AWVALID; awr_prev <= M_AXI_AWREADY; awaddr_prev <= M_AXI_AWADDR;
    wv_prev <= M_AXI_WVALID; wr_prev <= M_AXI_WREADY; w_prev <= {M_AXI_WSTRB, M_AXI_WDATA};
    arv_prev <= M_AXI_ARVALID; arr_prev <= M_AXI_ARREADY; araddr_prev <= M_AXI_ARADDR;
  end

  function automatic logic [31:0] mdl_read(input logic [15:0] a);
    return {mdl[a[5:0] + 6'd3], mdl[a[5:0] + 6'd2], mdl[a[5:0] + 6'd1], mdl[a[5:0]]};
  endfunction

  task automatic mdl_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) mdl[a[5:0] + 6'(i)] = d[8*i +: 8];
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic start_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
    int n = 0;
    while (!CMD_READY && n < 50) begin @(negedge clk); n++; end
    ok = CMD_READY;
    if (!ok) return;
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    @(negedge clk);
    CMD_VALID = 1'b0; CMD_WR = 1'($urandom); CMD_ADDR = 16'($urandom);
    CMD_WDATA = $urandom; CMD_WSTRB = 4'($urandom);
  endtask

  task automatic wait_rsp(input int start_cnt, output bit ok);
    int n = 0;
    while (rsp_cnt == start_cnt && n < 100) begin @(negedge clk); n++; end
    ok = (rsp_cnt != start_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({CMD_READY, RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 7'b0)
      $display("FAIL reset_handshakes got %b exp 0", {CMD_READY, RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); else n_pass++;
    n_checks++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB, RSP_RDATA, RSP_RESP, RSP_WR} !== '0)
      $display("FAIL reset_fields got awaddr %h wdata %h rdata %h exp 0", M_AXI_AWADDR, M_AXI_WDATA, RSP_RDATA); else n_pass++;
    n_checks++; if ({M_AXI_AWPROT, M_AXI_ARPROT} !== 6'b0)
      $display("FAIL reset_prot got %b exp 0", {M_AXI_AWPROT, M_AXI_ARPROT}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (CMD_READY !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", CMD_READY); else n_pass++;
  endtask

  task automatic test_write_basic();
    bit ok; int s = rsp_cnt;
    set_dly(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    start_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, ok);
    if (ok) wait_rsp(s, ok);
    mdl_write(16'h0010, 32'hDEADBEEF, 4'hF);
    n_checks++; if (!ok) $display("FAIL wr_basic_done got timeout exp response"); else n_pass++;
    n_checks++; if (aw_hs_cyc - acc_cyc !== 1) $display("FAIL wr_basic_aw_lat got %0d exp 1", aw_hs_cyc - acc_cyc); else n_pass++;
    n_checks++; if (w_hs_cyc - acc_cyc !== 1) $display("FAIL wr_basic_w_lat got %0d exp 1", w_hs_cyc - acc_cyc); else n_pass++;
    n_checks++; if (rsp_cyc - acc_cyc !== 3) $display("FAIL wr_basic_rsp_lat got %0d exp 3", rsp_cyc - acc_cyc); else n_pass++;
    n_checks++; if ({rsp_wr_s, rsp_resp_s, rsp_rdata_s} !== {1'b1, 2'b00, 32'h0})
      $display("FAIL wr_basic_rsp got wr %b resp %b rdata %h exp 1 00 0", rsp_wr_s, rsp_resp_s, rsp_rdata_s); else n_pass++;
  endtask

  task automatic test_write_aw_late();
    bit ok; int s = rsp_cnt; int awv0 = awv_cnt; int wv0 = wv_cnt;
    set_dly(4, 0, 0, 0, 0); bresp_cfg = 2'b00;
    start_cmd(1'b1, 16'h0020, 32'hA5A5_0F0F, 4'b0101, ok);
    if (ok) wait_rsp(s, ok);
    mdl_write(16'h0020, 32'hA5A5_0F0F, 4'b0101);
    n_checks++; if (!ok) $display("FAIL aw_late_done got timeout exp response"); else n_pass++;
    n_checks++; if (w_hs_cyc - acc_cyc !== 1) $display("FAIL aw_late_w_lat got %0d exp 1", w_hs_cyc - acc_cyc); else n_pass++;
    n_checks++; if (aw_hs_cyc - acc_cyc !== 5) $display("FAIL aw_late_aw_lat got %0d exp 5", aw_hs_cyc - acc_cyc); else n_pass++;
    n_checks++; if (br_rise_cyc - acc_cyc !== 6) $display("FAIL aw_late_bready got %0d exp 6", br_rise_cyc - acc_cyc); else n_pass++;
    n_checks++; if (wv_cnt - wv0 !== 1) $display("FAIL aw_late_wvalid_cycles got %0d exp 1", wv_cnt - wv0); else n_pass++;
    n_checks++; if (awv_cnt - awv0 !== 5) $display("FAIL aw_late_awvalid_cycles got %0d exp 5", awv_cnt - awv0); else n_pass++;
  endtask

  task automatic test_read_basic();
    bit ok; int s;
    set_dly(0, 0, 0, 0, 0); bresp_cfg = 2'b00; s = rsp_cnt;
    start_cmd(1'b1, 16'h0004, 32'h12345678, 4'hF, ok);
    if (ok) wait_rsp(s, ok);
    mdl_write(16'h0004, 32'h12345678, 4'hF);
    set_dly(0, 0, 0, 0, 2); rresp_cfg = 2'b00; s = rsp_cnt;
    if (ok) start_cmd(1'b0, 16'h0004, 32'h0, 4'h0, ok);
    if (ok) wait_rsp(s, ok);
    n_checks++; if (!ok) $display("FAIL rd_basic_done got timeout exp response"); else n_pass++;
    n_checks++; if (ar_hs_cyc - acc_cyc !== 1) $display("FAIL rd_basic_ar_lat got %0d exp 1", ar_hs_cyc - acc_cyc); else n_pass++;
    n_checks++; if (rsp_cyc - acc_cyc !== 5) $display("FAIL rd_basic_rsp_lat got %0d exp 5", rsp_cyc - acc_cyc); else n_pass++;
    n_checks++; if ({rsp_wr_s, rsp_resp_s, rsp_rdata_s} !== {1'b0, 2'b00, mdl_read(16'h0004)})
      $display("FAIL rd_basic_rsp got wr %b resp %b rdata %h exp 0 00 %h", rsp_wr_s, rsp_resp_s, rsp_rdata_s, mdl_read(16'h0004)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok; int s = rsp_cnt; int first_rsp;
    set_dly(0, 0, 0, 0, 0); rresp_cfg = 2'b10; bresp_cfg = 2'b00;
    start_cmd(1'b0, 16'h0010, 32'h0, 4'h0, ok);
    if (ok) wait_rsp(s, ok);
    n_checks++; if (!ok) $display("FAIL b2b_read_done got timeout exp response"); else n_pass++;
    n_checks++; if (rsp_cyc - acc_cyc !== 3) $display("FAIL b2b_read_lat got %0d exp 3", rsp_cyc - acc_cyc); else n_pass++;
    n_checks++; if ({rsp_resp_s, rsp_rdata_s} !== {2'b10, mdl_read(16'h0010)})
      $display("FAIL b2b_slverr got resp %b rdata %h exp 10 %h", rsp_resp_s, rsp_rdata_s, mdl_read(16'h0010)); else n_pass++;
    first_rsp = rsp_cyc; rresp_cfg = 2'b00; s = rsp_cnt;
    start_cmd(1'b1, 16'h0030, 32'h0BAD_F00D, 4'hF, ok);
    if (ok) wait_rsp(s, ok);
    mdl_write(16'h0030, 32'h0BAD_F00D, 4'hF);
    n_checks++; if (acc_cyc - first_rsp !== 1) $display("FAIL b2b_accept got %0d exp 1", acc_cyc - first_rsp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0; int s = rsp_cnt;
    set_dly(0, 0, 30, 0, 0); bresp_cfg = 2'b00;
    start_cmd(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'hF, ok);
    while (!M_AXI_BREADY && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (M_AXI_BREADY !== 1'b1) $display("FAIL rst_mid_reach_wr_b got %b exp 1", M_AXI_BREADY); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({M_AXI_BREADY, CMD_READY, RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID} !== 5'b0)
      $display("FAIL rst_mid_clear got %b exp 0", {M_AXI_BREADY, CMD_READY, RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID}); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; set_dly(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    s = rsp_cnt;
    start_cmd(1'b1, 16'h0008, 32'h5566_7788, 4'hF, ok);
    if (ok) wait_rsp(s, ok);
    mdl_write(16'h0008, 32'h5566_7788, 4'hF);
    n_checks++; if (!ok || rsp_cnt !== s + 1) $display("FAIL rst_mid_fresh got %0d responses exp 1", rsp_cnt - s); else n_pass++;
    n_checks++; if ({rsp_wr_s, rsp_resp_s} !== 3'b100) $display("FAIL rst_mid_fresh_rsp got %b exp 100", {rsp_wr_s, rsp_resp_s}); else n_pass++;
  endtask

  task automatic test_random();
    bit ok; logic wr; logic [15:0] a; logic [31:0] d, exp_d; logic [3:0] st; logic [1:0] exp_r; int s;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom); a = 16'($urandom_range(0, 15) * 4); d = $urandom; st = 4'($urandom);
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom);
      exp_r = wr ? bresp_cfg : rresp_cfg;
      exp_d = wr ? 32'h0 : mdl_read(a);
      if (wr) mdl_write(a, d, st);
      s = rsp_cnt;
      start_cmd(wr, a, d, st, ok);
      if (ok) wait_rsp(s, ok);
      n_checks++; if (!ok) $display("FAIL rand_%0d_done got timeout exp response", i); else n_pass++;
      n_checks++; if ({rsp_wr_s, rsp_resp_s, rsp_rdata_s} !== {wr, exp_r, exp_d})
        $display("FAIL rand_%0d_rsp got wr %b resp %b rdata %h exp %b %b %h", i, rsp_wr_s, rsp_resp_s, rsp_rdata_s, wr, exp_r, exp_d); else n_pass++;
    end
  endtask

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int s = rsp_cnt;
    set_dly(0, 0, 20, 0, 0); bresp_cfg = 2'b00;
    start_cmd(1'b1, 16'h0004, 32'h0, 4'h0, ok);
    if (ok) wait_rsp(s, ok);
    n_checks++; if (!ok) $display("FAIL timeout_rsp got timeout exp response"); else n_pass++;
    n_checks++; if (to_rise_cyc - br_rise_cyc !== TO - 1) $display("FAIL timeout_rise got %0d exp %0d", to_rise_cyc - br_rise_cyc, TO - 1); else n_pass++;
    n_checks++; if (TIMEOUT_O !== 1'b1) $display("FAIL timeout_sticky got %b exp 1", TIMEOUT_O); else n_pass++;
    set_dly(0, 0, 0, 0, 0); s = rsp_cnt;
    start_cmd(1'b0, 16'h0004, 32'h0, 4'h0, ok);
    n_checks++; if (TIMEOUT_O !== 1'b0) $display("FAIL timeout_clear got %b exp 0", TIMEOUT_O); else n_pass++;
    if (ok) wait_rsp(s, ok);
  endtask
`endif

  task automatic test_protocol();
    n_checks++; if (viol !== 0) $display("FAIL protocol_valid_stable got %0d violations exp 0", viol); else n_pass++;
    n_checks++; if (rsp_double !== 0) $display("FAIL rsp_single_cycle got %0d multi-cycle pulses exp 0", rsp_double); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 8'h0;
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_write_aw_late();
    test_read_basic();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got still running exp finished");
    $fatal(1, "time limit");
  end

endmodule
